// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
//
// Serial receive stage for the UART link. The asynchronous line i_rx is
// synchronised and oversampled at CLKS_PER_BIT clocks per bit. Frames are
// 8N1 by default (DATA_BITS data bits, LSB first). When the macro
// UART_RX_PARITY_EN is defined, the frame also carries one even-parity bit
// after the data bits. Each received byte is handed to the consumer through
// a valid/ready holding register.
//
// Ports
//   i_clk    : single rising-edge clock
//   i_rst    : synchronous, active-high reset
//   i_rx     : asynchronous serial line, idles high
//   i_ready  : consumer takes o_data when o_valid && i_ready
//   o_data   : byte held in the holding register
//   o_valid  : holding register is full
//   o_error  : status of the held frame
//              bit0 framing, bit1 parity, bit2 overrun, bit3 break
//   o_rts    : registered !o_valid, paces the remote transmitter
//
// Configuration macro
//   UART_RX_PARITY_EN : adds the PARITY state and the parity check. When it
//                       is undefined, o_error[1] is always 0.
//
// Parameters
//   CLKS_PER_BIT : clocks per bit period, 4 or more
//   DATA_BITS    : data bits per frame, 5 to 9
// ---------------------------------------------------------------------------
module uart_rx #(
   parameter int CLKS_PER_BIT = 16,
   parameter int DATA_BITS    = 8
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_rx,
   input  logic                 i_ready,
   output logic [DATA_BITS-1:0] o_data,
   output logic                 o_valid,
   output logic [3:0]           o_error,
   output logic                 o_rts
);

   localparam int PHASE_W = $clog2(CLKS_PER_BIT);
   localparam int IDX_W   = $clog2(DATA_BITS + 1);

   localparam logic [PHASE_W-1:0] PHASE_FULL = PHASE_W'(CLKS_PER_BIT - 1);
   localparam logic [PHASE_W-1:0] PHASE_HALF = PHASE_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [PHASE_W-1:0] PHASE_ONE  = PHASE_W'(1);
   localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(DATA_BITS - 1);
   localparam logic [IDX_W-1:0]   IDX_ONE    = IDX_W'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_RX_PARITY_EN
      S_PARITY,
`endif
      S_STOP
   } state_t;

   // Line synchroniser and edge detector
   logic rxMeta_q;
   logic rxSync_q;
   logic rxPrev_q;
   logic rxFall;

   // Receive FSM state, counters and frame capture
   state_t               state_q;
   logic [PHASE_W-1:0]   phase_q;
   logic [IDX_W-1:0]     idx_q;
   logic [DATA_BITS-1:0] shift_q;
   logic                 stopBit_q;
   logic                 commit_q;
   logic                 phaseZero;
`ifdef UART_RX_PARITY_EN
   logic                 parBit_q;
`endif

   // Holding register
   logic [DATA_BITS-1:0] data_q;
   logic [DATA_BITS-1:0] data_d;
   logic                 valid_q;
   logic                 valid_d;
   logic [3:0]           error_q;
   logic [3:0]           error_d;
   logic                 rts_q;

   // Status of the frame being committed
   logic                 accept;
   logic                 frameErr;
   logic                 parityErr;
   logic                 breakErr;

   // Two flops bring i_rx into the clock domain. Both reset to the idle
   // level so that leaving reset never looks like a start edge. The third
   // flop remembers the previous synchronised value so that a 1->0
   // transition can be seen as a start-bit edge.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rxMeta_q <= 1'b1;
         rxSync_q <= 1'b1;
         rxPrev_q <= 1'b1;
      end else begin
         rxMeta_q <= i_rx;
         rxSync_q <= rxMeta_q;
         rxPrev_q <= rxSync_q;
      end
   end

   assign rxFall    = rxPrev_q & ~rxSync_q;
   assign phaseZero = (phase_q == '0);

   // Receive FSM. The phase counter counts down to zero, and every bit
   // decision is made at zero. START is entered with half a bit loaded, so
   // every later sample (one full bit apart) falls in the middle of its bit.
   // Every state change reloads both counters, so neither counter can wrap
   // into a stale value.
   //
   // The stop-bit sample sets commit_q. The holding register then takes the
   // frame on the next edge. The FSM returns to IDLE at the middle of the
   // stop bit, so it is already armed for a start edge that follows with no
   // idle gap. shift_q is not rewritten until the next frame's first data
   // sample, so it is still valid when the commit is consumed.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= S_IDLE;
         phase_q   <= '0;
         idx_q     <= '0;
         shift_q   <= '0;
         stopBit_q <= 1'b1;
         commit_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parBit_q  <= 1'b0;
`endif
      end else begin
         commit_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (rxFall) begin
                  state_q <= S_START;
                  phase_q <= PHASE_HALF;
                  idx_q   <= '0;
               end
            end

            S_START: begin
               if (phaseZero) begin
                  if (rxSync_q) begin
                     // The line is high again at mid-start: treat it as a glitch
                     state_q <= S_IDLE;
                     phase_q <= '0;
                     idx_q   <= '0;
                  end else begin
                     state_q <= S_DATA;
                     phase_q <= PHASE_FULL;
                     idx_q   <= '0;
                  end
               end else begin
                  phase_q <= phase_q - PHASE_ONE;
               end
            end

            S_DATA: begin
               if (phaseZero) begin
                  for (int b = 0; b < DATA_BITS; b++) begin
                     if (idx_q == IDX_W'(b)) begin
                        shift_q[b] <= rxSync_q;
                     end
                  end
                  phase_q <= PHASE_FULL;
                  if (idx_q == IDX_LAST) begin
                     idx_q <= '0;
`ifdef UART_RX_PARITY_EN
                     state_q <= S_PARITY;
`else
                     state_q <= S_STOP;
`endif
                  end else begin
                     idx_q <= idx_q + IDX_ONE;
                  end
               end else begin
                  phase_q <= phase_q - PHASE_ONE;
               end
            end

`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
               if (phaseZero) begin
                  parBit_q <= rxSync_q;
                  state_q  <= S_STOP;
                  phase_q  <= PHASE_FULL;
                  idx_q    <= '0;
               end else begin
                  phase_q <= phase_q - PHASE_ONE;
               end
            end
`endif

            S_STOP: begin
               if (phaseZero) begin
                  stopBit_q <= rxSync_q;
                  commit_q  <= 1'b1;
                  state_q   <= S_IDLE;
                  phase_q   <= '0;
                  idx_q     <= '0;
               end else begin
                  phase_q <= phase_q - PHASE_ONE;
               end
            end

            default: begin
               state_q <= S_IDLE;
               phase_q <= '0;
               idx_q   <= '0;
            end
         endcase
      end
   end

   // Error flags of the frame being committed. Break means the line stayed
   // low for the whole frame: every data bit is zero and the stop bit is low.
   assign frameErr = ~stopBit_q;
   assign breakErr = (shift_q == '0) & ~stopBit_q;
`ifdef UART_RX_PARITY_EN
   assign parityErr = (^shift_q) ^ parBit_q;
`else
   assign parityErr = 1'b0;
`endif

   assign accept = valid_q & i_ready;

   // Next state of the holding register. A commit loads the register when
   // it is empty or is being emptied on this same edge. In that case the
   // accept and the load combine, and no overrun is reported. A commit into
   // a full register that is not being accepted drops the new frame and only
   // sets the sticky overrun flag. The old byte stays visible.
   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      error_d = error_q;
      if (commit_q && (!valid_q || i_ready)) begin
         data_d  = shift_q;
         valid_d = 1'b1;
         error_d = {breakErr, 1'b0, parityErr, frameErr};
      end else if (commit_q) begin
         error_d[2] = 1'b1;
      end else if (accept) begin
         valid_d = 1'b0;
         error_d = '0;
      end
   end

   // Holding register and flow control. o_rts follows o_valid one cycle
   // later. This keeps the remote transmitter's pacing signal glitch-free.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         data_q  <= '0;
         valid_q <= 1'b0;
         error_q <= '0;
         rts_q   <= 1'b1;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
         error_q <= error_d;
         rts_q   <= ~valid_q;
      end
   end

   assign o_data  = data_q;
   assign o_valid = valid_q;
   assign o_error = error_q;
   assign o_rts   = rts_q;

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
//
// Bench for uart_rx at the default parameters. A reference model computes
// each frame's error flags and receive latency directly from the frame
// contents, and these are compared with what the DUT presents. When
// UART_RX_PARITY_EN is defined, frames carry an even-parity bit and the
// parity scenario is added.
// ---------------------------------------------------------------------------
module tb_uart_rx;

   localparam int CPB = 16;
   localparam int DB  = 8;
`ifdef UART_RX_PARITY_EN
   localparam int PEN = 1;
`else
   localparam int PEN = 0;
`endif
   localparam int LAT = 3 + CPB / 2 + (DB + 1 + PEN) * CPB;

   logic          clk = 1'b0;
   logic          rst;
   logic          rx;
   logic          ready;
   logic [DB-1:0] data;
   logic          valid;
   logic [3:0]    error;
   logic          rts;

   int checks   = 0;
   int failures = 0;

   // Number of posedges seen so far. Read at negedges.
   int cycle = 0;
   // Index of the posedge that first samples the start bit of the last frame
   int lastStart = 0;

   // Monitor records of the most recent o_valid rise and fall
   int            riseCount = 0;
   int            lastRise  = 0;
   int            lastFall  = 0;
   logic [DB-1:0] riseData  = '0;
   logic [3:0]    riseErr   = '0;
   logic          riseRts   = 1'b0;
   logic          prevValid = 1'b0;

   uart_rx #(
      .CLKS_PER_BIT (CPB),
      .DATA_BITS    (DB)
   ) dut (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_rx    (rx),
      .i_ready (ready),
      .o_data  (data),
      .o_valid (valid),
      .o_error (error),
      .o_rts   (rts)
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Counts the posedges
   always @(posedge clk) cycle = cycle + 1;

   // Records the cycle and the contents at each o_valid rise, and the cycle
   // of each fall
   always @(negedge clk) begin
      if (valid && !prevValid) begin
         riseCount = riseCount + 1;
         lastRise  = cycle;
         riseData  = data;
         riseErr   = error;
         riseRts   = rts;
      end
      if (!valid && prevValid) lastFall = cycle;
      prevValid = valid;
   end

   // Reference model: the flags the held frame must report
   function automatic logic [3:0] modelError(input logic [DB-1:0] d, input logic stopBit,
                                             input logic parBit, input logic overrun);
      int   ones;
      logic parErr;
      ones   = $countones(d);
      parErr = (PEN != 0) && (((ones + int'(parBit)) % 2) != 0);
      return {(d == '0) && !stopBit, overrun, parErr, !stopBit};
   endfunction

   function automatic logic evenParity(input logic [DB-1:0] d);
      return ($countones(d) % 2) != 0;
   endfunction

   // Sends one frame with each bit held for CPB cycles. The line is left at
   // the stop-bit level.
   task automatic sendFrame(input logic [DB-1:0] d, input logic stopBit, input logic parBit);
      lastStart = cycle + 1;
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int b = 0; b < DB; b++) begin
         rx = d[b];
         repeat (CPB) @(negedge clk);
      end
      if (PEN != 0) begin
         rx = parBit;
         repeat (CPB) @(negedge clk);
      end
      rx = stopBit;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic idle(input int n);
      rx = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   task automatic acceptOne();
      ready = 1'b1;
      @(negedge clk);
      ready = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst   = 1'b1;
      rx    = 1'b1;
      ready = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (data !== 8'h00) begin failures++; $display("[TB] FAIL reset_data: got %h expected 00", data); end
      checks++; if (valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid: got %b expected 0", valid); end
      checks++; if (error !== 4'b0000) begin failures++; $display("[TB] FAIL reset_error: got %b expected 0000", error); end
      checks++; if (rts !== 1'b1) begin failures++; $display("[TB] FAIL reset_rts: got %b expected 1", rts); end
      rst = 1'b0;
      idle(20);
   endtask

   task automatic test_single();
      int r0;
      logic [DB-1:0] d;
      d     = 8'hA5;
      ready = 1'b1;
      r0    = riseCount;
      sendFrame(d, 1'b1, evenParity(d));
      idle(4);
      checks++; if (riseCount !== r0 + 1) begin failures++; $display("[TB] FAIL single_count: got %0d expected %0d", riseCount - r0, 1); end
      checks++; if (lastRise - lastStart !== LAT) begin failures++; $display("[TB] FAIL single_latency: got %0d expected %0d", lastRise - lastStart, LAT); end
      checks++; if (riseData !== d) begin failures++; $display("[TB] FAIL single_data: got %h expected %h", riseData, d); end
      checks++; if (riseErr !== modelError(d, 1'b1, evenParity(d), 1'b0)) begin failures++; $display("[TB] FAIL single_error: got %b expected %b", riseErr, modelError(d, 1'b1, evenParity(d), 1'b0)); end
      checks++; if (lastFall - lastRise !== 1) begin failures++; $display("[TB] FAIL single_pulse: got %0d expected 1", lastFall - lastRise); end
      checks++; if (riseRts !== 1'b1) begin failures++; $display("[TB] FAIL single_rts_lag: got %b expected 1", riseRts); end
      ready = 1'b0;
   endtask

   task automatic test_random();
      int r0, gap;
      logic [DB-1:0] d;
      logic stopBit, parBit;
      logic [3:0] expErr;
      ready = 1'b1;
      for (int n = 0; n < 8; n++) begin
         d       = DB'($urandom);
         stopBit = ($urandom_range(0, 3) != 0);
         parBit  = (PEN != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
         expErr  = modelError(d, stopBit, parBit, 1'b0);
         r0      = riseCount;
         sendFrame(d, stopBit, parBit);
         checks++; if (riseCount !== r0 + 1) begin failures++; $display("[TB] FAIL rand_count[%0d]: got %0d expected 1", n, riseCount - r0); end
         checks++; if (lastRise - lastStart !== LAT) begin failures++; $display("[TB] FAIL rand_latency[%0d]: got %0d expected %0d", n, lastRise - lastStart, LAT); end
         checks++; if (riseData !== d) begin failures++; $display("[TB] FAIL rand_data[%0d]: got %h expected %h", n, riseData, d); end
         checks++; if (riseErr !== expErr) begin failures++; $display("[TB] FAIL rand_error[%0d]: got %b expected %b", n, riseErr, expErr); end
         gap = stopBit ? $urandom_range(0, 10) : $urandom_range(1, 10);
         idle(gap);
      end
      idle(10);
      ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      int r0;
      ready = 1'b0;
      r0    = riseCount;
      sendFrame(8'h3C, 1'b1, evenParity(8'h3C));
      sendFrame(8'h7E, 1'b1, evenParity(8'h7E));
      idle(1);
      checks++; if (riseCount !== r0 + 1) begin failures++; $display("[TB] FAIL b2b_count: got %0d expected 1", riseCount - r0); end
      checks++; if (valid !== 1'b1) begin failures++; $display("[TB] FAIL b2b_valid: got %b expected 1", valid); end
      checks++; if (data !== 8'h3C) begin failures++; $display("[TB] FAIL b2b_data: got %h expected 3c", data); end
      checks++; if (error !== modelError(8'h3C, 1'b1, evenParity(8'h3C), 1'b1)) begin failures++; $display("[TB] FAIL b2b_error: got %b expected %b", error, modelError(8'h3C, 1'b1, evenParity(8'h3C), 1'b1)); end
      checks++; if (rts !== 1'b0) begin failures++; $display("[TB] FAIL b2b_rts: got %b expected 0", rts); end
      ready = 1'b1;
      @(negedge clk);
      ready = 1'b0;
      checks++; if (valid !== 1'b0) begin failures++; $display("[TB] FAIL b2b_accept_valid: got %b expected 0", valid); end
      checks++; if (error !== 4'b0000) begin failures++; $display("[TB] FAIL b2b_accept_error: got %b expected 0000", error); end
      @(negedge clk);
      checks++; if (rts !== 1'b1) begin failures++; $display("[TB] FAIL b2b_rts_return: got %b expected 1", rts); end
      idle(10);
   endtask

   task automatic test_accept_collision();
      int r0;
      logic [DB-1:0] obsData;
      logic [3:0] obsErr;
      logic obsValid;
      logic timedOut;
      ready    = 1'b0;
      timedOut = 1'b0;
      obsData  = '0;
      obsErr   = '0;
      obsValid = 1'b0;
      sendFrame(8'h5A, 1'b1, evenParity(8'h5A));
      idle(5);
      checks++; if (data !== 8'h5A) begin failures++; $display("[TB] FAIL coll_first: got %h expected 5a", data); end
      r0 = riseCount;
      // i_ready is raised for exactly the edge on which the second frame commits
      fork
         sendFrame(8'hC3, 1'b1, evenParity(8'hC3));
         begin
            int guard;
            guard = 0;
            @(negedge clk);
            while (cycle != lastStart + LAT - 1 && guard < 1000) begin
               @(negedge clk);
               guard++;
            end
            if (guard >= 1000) timedOut = 1'b1;
            ready = 1'b1;
            @(negedge clk);
            ready    = 1'b0;
            obsData  = data;
            obsErr   = error;
            obsValid = valid;
         end
      join
      idle(2);
      checks++; if (timedOut !== 1'b0) begin failures++; $display("[TB] FAIL coll_timeout: got %b expected 0", timedOut); end
      checks++; if (obsValid !== 1'b1) begin failures++; $display("[TB] FAIL coll_valid: got %b expected 1", obsValid); end
      checks++; if (obsData !== 8'hC3) begin failures++; $display("[TB] FAIL coll_data: got %h expected c3", obsData); end
      checks++; if (obsErr !== modelError(8'hC3, 1'b1, evenParity(8'hC3), 1'b0)) begin failures++; $display("[TB] FAIL coll_error: got %b expected %b", obsErr, modelError(8'hC3, 1'b1, evenParity(8'hC3), 1'b0)); end
      checks++; if (riseCount !== r0) begin failures++; $display("[TB] FAIL coll_norise: got %0d expected 0", riseCount - r0); end
      acceptOne();
      idle(5);
   endtask

   task automatic test_break();
      ready = 1'b0;
      sendFrame(8'h00, 1'b0, 1'b0);
      idle(4);
      checks++; if (valid !== 1'b1) begin failures++; $display("[TB] FAIL break_valid: got %b expected 1", valid); end
      checks++; if (data !== 8'h00) begin failures++; $display("[TB] FAIL break_data: got %h expected 00", data); end
      checks++; if (error !== modelError(8'h00, 1'b0, 1'b0, 1'b0)) begin failures++; $display("[TB] FAIL break_error: got %b expected %b", error, modelError(8'h00, 1'b0, 1'b0, 1'b0)); end
      acceptOne();
      idle(5);
   endtask

   task automatic test_glitch();
      int r0;
      logic [DB-1:0] d;
      ready = 1'b1;
      r0    = riseCount;
      d     = DB'($urandom);
      rx    = 1'b0;
      repeat (6) @(negedge clk);
      idle(6);
      // A real frame whose start edge is sampled 12 cycles after the glitch began
      sendFrame(d, 1'b1, evenParity(d));
      idle(4);
      checks++; if (riseCount !== r0 + 1) begin failures++; $display("[TB] FAIL glitch_count: got %0d expected 1", riseCount - r0); end
      checks++; if (riseData !== d) begin failures++; $display("[TB] FAIL glitch_data: got %h expected %h", riseData, d); end
      checks++; if (lastRise - lastStart !== LAT) begin failures++; $display("[TB] FAIL glitch_latency: got %0d expected %0d", lastRise - lastStart, LAT); end
      ready = 1'b0;
   endtask

`ifdef UART_RX_PARITY_EN
   task automatic test_parity();
      ready = 1'b0;
      sendFrame(8'h81, 1'b1, 1'b1);
      idle(4);
      checks++; if (data !== 8'h81) begin failures++; $display("[TB] FAIL parity_bad_data: got %h expected 81", data); end
      checks++; if (error !== 4'b0010) begin failures++; $display("[TB] FAIL parity_bad_error: got %b expected 0010", error); end
      acceptOne();
      sendFrame(8'h81, 1'b1, 1'b0);
      idle(4);
      checks++; if (data !== 8'h81) begin failures++; $display("[TB] FAIL parity_ok_data: got %h expected 81", data); end
      checks++; if (error !== 4'b0000) begin failures++; $display("[TB] FAIL parity_ok_error: got %b expected 0000", error); end
      acceptOne();
      idle(5);
   endtask
`endif

   task automatic test_reset_midframe();
      int r0;
      logic [DB-1:0] d;
      ready = 1'b0;
      sendFrame(8'h99, 1'b1, evenParity(8'h99));
      idle(3);
      // Partial frame of 0xF0, with reset applied in the middle of data bit 4
      d  = 8'hF0;
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int b = 0; b < 4; b++) begin
         rx = d[b];
         repeat (CPB) @(negedge clk);
      end
      rx = d[4];
      repeat (CPB / 2) @(negedge clk);
      rst = 1'b1;
      rx  = 1'b1;
      @(negedge clk);
      checks++; if (data !== 8'h00) begin failures++; $display("[TB] FAIL midrst_data: got %h expected 00", data); end
      checks++; if (valid !== 1'b0) begin failures++; $display("[TB] FAIL midrst_valid: got %b expected 0", valid); end
      checks++; if (error !== 4'b0000) begin failures++; $display("[TB] FAIL midrst_error: got %b expected 0000", error); end
      checks++; if (rts !== 1'b1) begin failures++; $display("[TB] FAIL midrst_rts: got %b expected 1", rts); end
      rst = 1'b0;
      r0  = riseCount;
      idle(CPB * 12);
      checks++; if (riseCount !== r0) begin failures++; $display("[TB] FAIL midrst_ghost: got %0d expected 0", riseCount - r0); end
      ready = 1'b1;
      sendFrame(8'h55, 1'b1, evenParity(8'h55));
      idle(4);
      checks++; if (riseCount !== r0 + 1) begin failures++; $display("[TB] FAIL midrst_next_count: got %0d expected 1", riseCount - r0); end
      checks++; if (riseData !== 8'h55) begin failures++; $display("[TB] FAIL midrst_next_data: got %h expected 55", riseData); end
      checks++; if (riseErr !== modelError(8'h55, 1'b1, evenParity(8'h55), 1'b0)) begin failures++; $display("[TB] FAIL midrst_next_error: got %b expected %b", riseErr, modelError(8'h55, 1'b1, evenParity(8'h55), 1'b0)); end
      ready = 1'b0;
   endtask

   // Runs the scenarios in order and prints the summary line
   initial begin
      test_reset();
      test_single();
      test_random();
      test_back_to_back();
      test_accept_collision();
      test_break();
      test_glitch();
`ifdef UART_RX_PARITY_EN
      test_parity();
`endif
      test_reset_midframe();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
